// File: rtl/aes_decipher_iter.sv
// Iterative AES-128 inverse cipher: expands the key schedule (or reuses a cached one),
// then runs one inverse round per clock. One block in flight, valid/ready on both sides.
module aes_decipher_iter #(
  parameter int LENGTH    = 128,
  parameter int NR        = 10,
  parameter int KEY_REUSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LENGTH-1:0] cipher_text,
  input  logic [LENGTH-1:0] key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LENGTH-1:0] plain_text,
  output logic              busy
);

  typedef enum logic [2:0] {IDLE, KEXP, ARK0, DEC, DONE} fsm_t;

  localparam logic [3:0] LAST = 4'(NR);

  fsm_t              fsm;
  logic [3:0]        rnd;
  logic              cache_vld;
  logic [LENGTH-1:0] cached_key;
  logic [LENGTH-1:0] blk;
  logic [LENGTH-1:0] rk [0:NR];
  logic [LENGTH-1:0] rk_cur, rk_prev, kexp_next, dec_core, dec_next;
  logic              hit;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = a;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), a);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s;
    s = gf_inv(a);
    return s ^ rotl8(s, 1) ^ rotl8(s, 2) ^ rotl8(s, 3) ^ rotl8(s, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  // Byte i sits at row i%4, column i/4; row r rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_exp(input logic [127:0] prev, input logic [3:0] r);
    logic [31:0] w3, t, n0, n1, n2, n3;
    w3 = prev[31:0];
    t  = {sbox(w3[23:16]) ^ rcon(r), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    n0 = prev[127:96] ^ t;
    n1 = prev[95:64] ^ n0;
    n2 = prev[63:32] ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  always_comb begin
    rk_cur  = '0;
    rk_prev = '0;
    for (int i = 0; i <= NR; i++) begin
      if (rnd == 4'(i))     rk_cur  = rk[i];
      if (rnd == 4'(i + 1)) rk_prev = rk[i];
    end
    kexp_next = key_exp(rk_prev, rnd);
    dec_core  = inv_sub_bytes(inv_shift_rows(blk));
    dec_next  = (rnd == 4'd0) ? (dec_core ^ rk_cur) : inv_mix_columns(dec_core ^ rk_cur);
    hit       = (KEY_REUSE != 0) && cache_vld && (key == cached_key);
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      plain_text <= '0;
      busy       <= 1'b0;
      rnd        <= 4'd0;
      cache_vld  <= 1'b0;
    end else begin
      case (fsm)
        IDLE: if (in_valid) begin
          rnd      <= 4'd1;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (hit) fsm <= ARK0;
          else begin
            fsm       <= KEXP;
            cache_vld <= 1'b0;
          end
        end
        KEXP: if (rnd == LAST) begin
          rnd       <= LAST - 4'd1;
          cache_vld <= (KEY_REUSE != 0);
          fsm       <= DEC;
        end else rnd <= rnd + 4'd1;
        ARK0: begin
          rnd <= LAST - 4'd1;
          fsm <= DEC;
        end
        DEC: if (rnd == 4'd0) begin
          plain_text <= dec_next;
          out_valid  <= 1'b1;
          fsm        <= DONE;
        end else rnd <= rnd - 4'd1;
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  // Datapath: block state, round keys and cached key carry no reset
  always_ff @(posedge clk) begin
    case (fsm)
      IDLE: if (in_valid) begin
        blk   <= cipher_text;
        rk[0] <= key;
      end
      KEXP: begin
        for (int i = 1; i <= NR; i++)
          if (rnd == 4'(i)) rk[i] <= kexp_next;
        if (rnd == LAST) begin
          blk        <= blk ^ kexp_next;
          cached_key <= rk[0];
        end
      end
      ARK0:    blk <= blk ^ rk[NR];
      DEC:     blk <= dec_next;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_decipher_iter.sv
// Bench for aes_decipher_iter: FIPS vectors, key cache, backpressure, mid-op reset and
// randomized blocks produced by a byte-level AES encryption model.
module tb_aes_decipher_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] cipher_text = '0;
  logic [127:0] key = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] plain_text;
  logic         busy;

  int checks = 0;
  int failures = 0;

  logic [7:0] sb [256];

  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decipher_iter dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_text(cipher_text), .key(key), .out_valid(out_valid),
    .out_ready(out_ready), .plain_text(plain_text), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Classic generator: walk p over GF(2^8)* by powers of 3 while q tracks 1/p.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] w [176];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
      if (i % 16 == 0) begin
        a0 = tmp[0];
        tmp[0] = sb[tmp[1]] ^ rc;
        tmp[1] = sb[tmp[2]];
        tmp[2] = sb[tmp[3]];
        tmp[3] = sb[a0];
        rc = xt(rc);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[row+4*c] = sb[s[row+4*((c+row)%4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[16*r+i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one block and collects its result; lat = edges from accept to out_valid, -1 on timeout.
  task automatic run_block(input logic [127:0] ct, input logic [127:0] k, input int in_gap,
                           input int out_gap, output logic [127:0] pt, output int lat);
    int n;
    repeat (in_gap) step();
    cipher_text = ct;
    key = k;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin step(); lat++; end
    if (!out_valid) lat = -1;
    pt = plain_text;
    repeat (out_gap) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (plain_text !== 128'h0) begin failures++; $display("FAIL reset_plain_text: got %h expected 0", plain_text); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_fips_c1();
    logic [127:0] pt;
    int lat;
    run_block(C1_CT, C1_KEY, 0, 0, pt, lat);
    checks++;
    if (pt !== C1_PT) begin failures++; $display("FAIL c1_pt: got %h expected %h", pt, C1_PT); end
    checks++;
    if (lat !== 20) begin failures++; $display("FAIL c1_latency: got %0d expected 20", lat); end
  endtask

  task automatic test_cache_hit();
    logic [127:0] pt;
    int lat;
    run_block(C1_CT, C1_KEY, 1, 0, pt, lat);
    checks++;
    if (pt !== C1_PT) begin failures++; $display("FAIL hit_pt: got %h expected %h", pt, C1_PT); end
    checks++;
    if (lat !== 11) begin failures++; $display("FAIL hit_latency: got %0d expected 11", lat); end
    run_block(B_CT, B_KEY, 0, 2, pt, lat);
    checks++;
    if (pt !== B_PT) begin failures++; $display("FAIL fips_b_pt: got %h expected %h", pt, B_PT); end
    checks++;
    if (lat !== 20) begin failures++; $display("FAIL keychange_latency: got %0d expected 20", lat); end
  endtask

  task automatic test_backpressure();
    logic [127:0] held;
    int n;
    cipher_text = C1_CT;
    key = C1_KEY;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    held = plain_text;
    checks++;
    if (held !== C1_PT) begin failures++; $display("FAIL bp_pt: got %h expected %h", held, C1_PT); end
    for (int i = 0; i < 7; i++) begin
      step();
      checks++;
      if (plain_text !== held || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold cycle %0d: got %h/%b expected %h/1", i, plain_text, out_valid, held);
      end
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL bp_flags cycle %0d: got in_ready=%b busy=%b expected 0/1", i, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
    step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_single_handshake: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_midop();
    logic [127:0] pt;
    int lat, n;
    cipher_text = B_CT;
    key = B_KEY;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL midop_async: got out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midop_busy: got %b expected 0", busy); end
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (25) step();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL midop_discard: got %b expected 0", out_valid); end
    run_block(C1_CT, C1_KEY, 0, 0, pt, lat);
    checks++;
    if (pt !== C1_PT) begin failures++; $display("FAIL midop_pt: got %h expected %h", pt, C1_PT); end
    checks++;
    if (lat !== 20) begin failures++; $display("FAIL midop_latency: got %0d expected 20", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] k, pa, pb, ca, cb;
    int n;
    k = rand128();
    pa = rand128();
    pb = rand128();
    ca = aes_encrypt(pa, k);
    cb = aes_encrypt(pb, k);
    out_ready = 1'b1;
    cipher_text = ca;
    key = k;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    step();
    cipher_text = cb;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    checks++;
    if (plain_text !== pa || n !== 20) begin
      failures++; $display("FAIL b2b_first: got %h lat %0d expected %h lat 20", plain_text, n, pa);
    end
    n = 0;
    while (!in_ready && n < 200) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin step(); n++; end
    checks++;
    if (plain_text !== pb || n !== 11) begin
      failures++; $display("FAIL b2b_second: got %h lat %0d expected %h lat 11", plain_text, n, pb);
    end
    step();
    out_ready = 1'b0;
    key = k;
  endtask

  task automatic test_random(input logic [127:0] start_key);
    logic [127:0] k, last_k, p, c, got;
    int lat, exp_lat;
    last_k = start_key;
    for (int i = 0; i < 1000; i++) begin
      k = ($urandom_range(0, 3) == 0) ? last_k : rand128();
      p = rand128();
      c = aes_encrypt(p, k);
      exp_lat = (k == last_k) ? 11 : 20;
      run_block(c, k, $urandom_range(0, 2), $urandom_range(0, 3), got, lat);
      checks++;
      if (got !== p) begin failures++; $display("FAIL rand_pt[%0d]: got %h expected %h", i, got, p); end
      checks++;
      if (lat !== exp_lat) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      last_k = k;
    end
  endtask

  initial begin
    logic [127:0] b2b_key;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    step();
    test_fips_c1();
    test_cache_hit();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    b2b_key = key;
    test_random(b2b_key);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
